// File: rtl/ofmap_collector.sv
// Output-stage collector: sums row-end PE results per output index, then drains the ofmap.
// Define SPIKE_OUT_EN to emit a thresholded spike bit instead of the raw sum.
module ofmap_collector #(
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_DATA = 13,
  parameter int NUM_ROWS   = 5,
  parameter int DEPTH_R    = 21,
  parameter int THRESHOLD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_PKT-1:0]  pkt_in,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  output logic [WIDTH_DATA+2:0] out_data,
  output logic [4:0]            out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  pkt_err
);

  localparam int AccW  = WIDTH_DATA + 3;
  localparam int Total = NUM_ROWS * DEPTH_R;
  localparam int TotW  = $clog2(Total + 1);

  typedef enum logic {StCollect, StDrain} state_e;

  state_e          state_q, state_d;
  logic            run_q;
  logic [AccW-1:0] acc_q [DEPTH_R];
  logic [AccW-1:0] acc_d [DEPTH_R];
  // One bit wider than an index so a row that has filled all 32 slots still reads as full.
  logic [5:0]      wptr_q [NUM_ROWS];
  logic [5:0]      wptr_d [NUM_ROWS];
  logic [TotW-1:0] total_q, total_d;
  logic [4:0]      idx_q, idx_d;
  logic            frame_done_q, frame_done_d;
  logic            pkt_err_q, pkt_err_d;

  logic [2:0]            pkt_type;
  logic [4:0]            src_y;
  logic [WIDTH_DATA-1:0] pkt_data;
  logic                  row_ok;
  logic [5:0]            cur_wptr;
  logic                  pkt_ok;
  logic [AccW-1:0]       drain_acc;

  assign pkt_type = pkt_in[WIDTH_PKT-1 -: 3];
  assign src_y    = pkt_in[20:16];
  assign pkt_data = pkt_in[WIDTH_DATA-1:0];

  always_comb begin
    row_ok   = 1'b0;
    cur_wptr = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (src_y == 5'(r)) begin
        row_ok   = 1'b1;
        cur_wptr = wptr_q[r];
      end
    end
    pkt_ok = (pkt_type == 3'b011) && row_ok && (cur_wptr < 6'(DEPTH_R));
  end

  always_comb begin
    drain_acc = '0;
    for (int i = 0; i < DEPTH_R; i++) begin
      if (idx_q == 5'(i)) drain_acc = acc_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    wptr_d       = wptr_q;
    total_d      = total_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    pkt_err_d    = 1'b0;
    pkt_ready    = 1'b0;
    out_valid    = 1'b0;
    unique case (state_q)
      StCollect: begin
        pkt_ready = run_q;
        if (pkt_valid && run_q) begin
          if (pkt_ok) begin
            for (int i = 0; i < DEPTH_R; i++) begin
              if (cur_wptr == 6'(i)) acc_d[i] = acc_q[i] + AccW'(pkt_data);
            end
            for (int r = 0; r < NUM_ROWS; r++) begin
              if (src_y == 5'(r)) wptr_d[r] = wptr_q[r] + 6'd1;
            end
            total_d = total_q + TotW'(1);
            if (total_q == TotW'(Total - 1)) begin
              state_d = StDrain;
              idx_d   = '0;
            end
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == 5'(DEPTH_R - 1)) begin
            for (int i = 0; i < DEPTH_R; i++) acc_d[i] = '0;
            for (int r = 0; r < NUM_ROWS; r++) wptr_d[r] = '0;
            total_d      = '0;
            idx_d        = '0;
            frame_done_d = 1'b1;
            state_d      = StCollect;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
    endcase
  end

`ifdef SPIKE_OUT_EN
  assign out_data = out_valid ? {{(AccW-1){1'b0}}, (drain_acc >= AccW'(THRESHOLD))} : '0;
`else
  assign out_data = out_valid ? drain_acc : '0;
`endif
  assign out_idx    = idx_q;
  assign frame_done = frame_done_q;
  assign pkt_err    = pkt_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCollect;
      run_q        <= 1'b0;
      for (int i = 0; i < DEPTH_R; i++) acc_q[i] <= '0;
      for (int r = 0; r < NUM_ROWS; r++) wptr_q[r] <= '0;
      total_q      <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      for (int i = 0; i < DEPTH_R; i++) acc_q[i] <= acc_d[i];
      for (int r = 0; r < NUM_ROWS; r++) wptr_q[r] <= wptr_d[r];
      total_q      <= total_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_ofmap_collector.sv
// Directed bench for ofmap_collector: frames, drops, stalled drain, back-to-back frames, reset.
module tb_ofmap_collector;

  localparam int NR = 5;
  localparam int DR = 21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_in = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [15:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_done;
  logic        pkt_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_acc [DR];

  ofmap_collector #(
    .WIDTH_PKT (32),
    .WIDTH_DATA(13),
    .NUM_ROWS  (NR),
    .DEPTH_R   (DR),
    .THRESHOLD (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_in    (pkt_in),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .pkt_err   (pkt_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int exp_out(input int v);
`ifdef SPIKE_OUT_EN
    return (v >= 16) ? 1 : 0;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [4:0] y, input logic [12:0] d);
    pkt_in    = {t, 5'd0, 3'd0, y, 3'd0, d};
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic send_good(input int y, input int idx, input int d);
    send(3'b011, 5'(y), 13'(d));
    exp_acc[idx] += d;
  endtask

  task automatic send_bad(input string tag, input logic [2:0] t, input int y, input int d);
    send(t, 5'(y), 13'(d));
    @(negedge clk);
    check(tag, pkt_err, 1);
  endtask

  // mode 0: data = idx+1, mode 1: 8191, mode 2: 1, mode 3: sums 15/16 at idx 0/1
  function automatic int frame_val(input int mode, input int r, input int idx);
    case (mode)
      0: return idx + 1;
      1: return 8191;
      3: return (idx == 0) ? 3 : (idx == 1) ? ((r == 0) ? 4 : 3) : 1;
      default: return 1;
    endcase
  endfunction

  task automatic fill_rr(input int mode);
    for (int idx = 0; idx < DR; idx++) begin
      for (int r = 0; r < NR; r++) begin
        if (idx == DR - 1 && r == NR - 1) begin
          @(negedge clk);
          check("pre_last_ready", pkt_ready, 1);
        end
        send_good(r, idx, frame_val(mode, r, idx));
      end
    end
  endtask

  task automatic drain(input bit stall, input bit hold_valid);
    int n = 0;
    int cyc = 0;
    bit pstall = 1'b0;
    logic [15:0] pd = '0;
    logic [4:0] pi = '0;
    pkt_in    = {3'b011, 5'd0, 3'd0, 5'd0, 3'd0, 13'd1};
    pkt_valid = hold_valid;
    while (n < DR && cyc < 200) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      check("drain_valid", out_valid, 1);
      check("drain_pkt_ready", pkt_ready, 0);
      if (pstall) begin
        check("stall_hold_data", out_data, pd);
        check("stall_hold_idx", out_idx, pi);
      end
      if (out_ready) begin
        check("drain_idx", out_idx, n);
        check("drain_data", out_data, exp_out(exp_acc[n]));
        n++;
      end
      pd = out_data;
      pi = out_idx;
      pstall = !out_ready;
      step();
      cyc++;
    end
    if (n < DR) check("drain_timeout", n, DR);
    if (!stall) check("drain_cycles", cyc, DR);
    out_ready = 1'b0;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("frame_done_pulse", frame_done, 1);
    check("done_pkt_ready", pkt_ready, 1);
    check("done_out_valid", out_valid, 0);
    step();
    @(negedge clk);
    check("frame_done_one_cycle", frame_done, 0);
    for (int i = 0; i < DR; i++) exp_acc[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < DR; i++) exp_acc[i] = 0;

    // Reset values and pkt_ready release.
    step();
    step();
    @(negedge clk);
    check("rst_pkt_ready", pkt_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pkt_err", pkt_err, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_rise", pkt_ready, 0);
    step();
    @(negedge clk);
    check("ready_after_rise", pkt_ready, 1);

    // Frame 1: row 2 first plus an overflow packet, bad type, bad row, then the rest.
    for (int idx = 0; idx < DR; idx++) begin
      send_good(2, idx, idx + 1);
      if (idx == 0) begin
        @(negedge clk);
        check("good_no_err", pkt_err, 0);
      end
    end
    send_bad("err_row_overflow", 3'b011, 2, 7);
    send_bad("err_type", 3'b010, 0, 9);
    send_bad("err_row_range", 3'b011, 6, 9);
    @(negedge clk);
    check("err_one_cycle", pkt_err, 0);
    for (int idx = 0; idx < DR; idx++) begin
      for (int r = 0; r < NR; r++) begin
        if (r != 2) begin
          if (idx == DR - 1 && r == NR - 1) begin
            @(negedge clk);
            check("f1_pre_last_ready", pkt_ready, 1);
          end
          send_good(r, idx, idx + 1);
        end
      end
    end
    drain(1'b0, 1'b0);

    // Frame 2: full-scale values, stalled drain with pkt_valid held high.
    fill_rr(1);
    drain(1'b1, 1'b1);

    // Frame 3: all ones straight after, must show no residue.
    fill_rr(2);
    drain(1'b0, 1'b0);

    // Frame 4: sums 15 and 16 at indices 0 and 1, then reset mid-drain.
    fill_rr(3);
    out_ready = 1'b1;
    @(negedge clk);
    check("f4_idx0", out_data, exp_out(15));
    step();
    @(negedge clk);
    check("f4_idx1", out_data, exp_out(16));
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_pkt_ready", pkt_ready, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_idx", out_idx, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_before", pkt_ready, 0);
    step();
    @(negedge clk);
    check("midrst_ready_after", pkt_ready, 1);
    for (int i = 0; i < DR; i++) exp_acc[i] = 0;

    // Frame 5: clean frame after reset.
    fill_rr(2);
    drain(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
